// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module : data_memory_responder
// Desc   : Memory side of the dcache line interface. Serves one 256-bit line
//          read/write at a time and acks after a fixed LATENCY. The optional
//          macro MEM_OOR_CHECK_EN flags and suppresses out-of-range lines.
// Rev    : 1.0  initial release
// ============================================================================
module data_memory_responder #(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 512
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    input  logic         enable_i,
    input  logic         write_i,
    output logic         ack_o,
    output logic [255:0] data_o,
    output logic         err_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   lat_idx;
    logic [255:0]       lat_data;
    logic               lat_write;
    logic               lat_oor;
    logic [255:0]       mem [DEPTH];

    logic               accept;
    logic               complete;
    logic [IDX_W-1:0]   in_idx;
    logic               in_oor;
    logic [IDX_W-1:0]   op_idx;
    logic [255:0]       op_data;
    logic               op_write;
    logic               op_oor;
    logic               unused_addr;

    assign in_idx = addr_i[5 +: IDX_W];

`ifdef MEM_OOR_CHECK_EN
    localparam logic [26:0] LINES = 27'(DEPTH);
    assign in_oor      = (addr_i[31:5] >= LINES);
    assign unused_addr = ^addr_i[4:0];
`else
    assign in_oor      = 1'b0;
    assign unused_addr = ^{addr_i[31:5+IDX_W], addr_i[4:0]};
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        complete   = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable_i) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        next_state = S_ACK;
                        complete   = 1'b1;
                    end else begin
                        next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    next_state = S_ACK;
                    complete   = 1'b1;
                end
            end
            S_ACK:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // With LATENCY=1 completion coincides with acceptance, so use the live inputs
    always_comb begin
        if (state == S_IDLE) begin
            op_idx   = in_idx;
            op_data  = data_i;
            op_write = write_i;
            op_oor   = in_oor;
        end else begin
            op_idx   = lat_idx;
            op_data  = lat_data;
            op_write = lat_write;
            op_oor   = lat_oor;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt    <= '0;
            ack_o  <= 1'b0;
            data_o <= '0;
        end else begin
            ack_o <= complete;
            if (accept) begin
                lat_idx   <= in_idx;
                lat_data  <= data_i;
                lat_write <= write_i;
                lat_oor   <= in_oor;
                cnt       <= CNT_W'(LATENCY - 1);
            end else if (state == S_WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (complete && !op_write) begin
                data_o <= op_oor ? '0 : mem[op_idx];
            end
        end
    end

    // Array is deliberately left uninitialised by reset
    always_ff @(posedge clk_i) begin
        if (!rst_i && complete && op_write && !op_oor) begin
            mem[op_idx] <= op_data;
        end
    end

`ifdef MEM_OOR_CHECK_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else begin
            err_o <= complete && op_oor;
        end
    end
`else
    assign err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_data_memory_responder
// Desc   : Self-checking bench for data_memory_responder against a line-array
//          reference model; directed scenarios followed by random requests.
// Rev    : 1.0  initial release
// ============================================================================
module tb_data_memory_responder;
    localparam int LATENCY = 10;
    localparam int DEPTH   = 512;

    logic         clk;
    logic         rst_i;
    logic [31:0]  addr_i;
    logic [255:0] data_i;
    logic         enable_i;
    logic         write_i;
    logic         ack_o;
    logic [255:0] data_o;
    logic         err_o;

    logic [255:0] model_mem [DEPTH];
    logic [255:0] exp_dout;
    int           checks;
    int           errors;

    data_memory_responder #(
        .LATENCY (LATENCY),
        .DEPTH   (DEPTH)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .enable_i (enable_i),
        .write_i  (write_i),
        .ack_o    (ack_o),
        .data_o   (data_o),
        .err_o    (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic is_oor(input logic [31:0] a);
`ifdef MEM_OOR_CHECK_EN
        return (a >> 5) >= DEPTH;
`else
        return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
    endfunction

    task automatic drive(input logic [31:0] a, input logic [255:0] d, input logic w);
        addr_i   = a;
        data_i   = d;
        write_i  = w;
        enable_i = 1'b1;
    endtask

    // Counts falling edges after acceptance until ack is seen; 0 means timeout
    task automatic wait_ack(output int lat);
        lat = 0;
        for (int k = 1; k <= 4 * LATENCY; k++) begin
            @(negedge clk);
            if (ack_o) begin
                lat = k;
                break;
            end
        end
    endtask

    // Evaluated while ack is high: apply the request to the model, compare outputs
    task automatic complete_check(input logic [31:0] a, input logic [255:0] d, input logic w);
        int   idx;
        logic oor;
        idx = (a >> 5) % DEPTH;
        oor = is_oor(a);
        if (w) begin
            if (!oor) model_mem[idx] = d;
        end else begin
            exp_dout = oor ? '0 : model_mem[idx];
        end
        check("data_o", data_o, exp_dout);
        check("err_o", 256'(err_o), 256'(oor));
    endtask

    // One request; during WAIT the inputs are replaced with alt_a / ~d / ~w
    task automatic req(input logic [31:0] a, input logic [255:0] d, input logic w,
                       input logic [31:0] alt_a);
        int lat;
        drive(a, d, w);
        @(posedge clk); #1;
        enable_i = 1'b0;
        addr_i   = alt_a;
        data_i   = ~d;
        write_i  = ~w;
        wait_ack(lat);
        check("ack_latency", 256'(lat), 256'(LATENCY));
        if (lat != 0) complete_check(a, d, w);
        @(posedge clk); #1;
        check("ack_pulse", 256'(ack_o), 256'(0));
    endtask

    initial begin
        logic [255:0] v;
        logic [31:0]  a;
        int           lat;

        checks   = 0;
        errors   = 0;
        exp_dout = '0;
        rst_i    = 1'b1;
        enable_i = 1'b0;
        write_i  = 1'b0;
        addr_i   = '0;
        data_i   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v = rand256();
            model_mem[i] = v;
            dut.mem[i]   = v;
        end

        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", 256'(ack_o), 256'(0));
        check("rst_data", data_o, '0);
        check("rst_err", 256'(err_o), 256'(0));
        rst_i = 1'b0;
        @(posedge clk); #1;

        // Write then read back line 2
        req(32'h40, {8{32'hDEADBEEF}}, 1'b1, 32'h40);
        req(32'h40, '0, 1'b0, 32'h40);
        check("rd_0x40", data_o, {8{32'hDEADBEEF}});

        // Inputs changed during WAIT must not matter: expect line 4
        req(32'h80, rand256(), 1'b0, 32'hC0);
        check("latched_line4", data_o, model_mem[4]);

        // Back-to-back with enable held through ACK
        v = rand256();
        drive(32'h100, v, 1'b1);
        @(posedge clk); #1;
        drive(32'h100, '0, 1'b0);
        wait_ack(lat);
        check("b2b_lat1", 256'(lat), 256'(LATENCY));
        if (lat != 0) complete_check(32'h100, v, 1'b1);
        @(posedge clk); #1;
        check("b2b_gap", 256'(ack_o), 256'(0));
        @(posedge clk); #1;
        enable_i = 1'b0;
        wait_ack(lat);
        check("b2b_lat2", 256'(lat), 256'(LATENCY));
        if (lat != 0) complete_check(32'h100, '0, 1'b0);
        check("b2b_data", data_o, v);
        @(posedge clk); #1;

        // Reset in the middle of a write to line 16
        drive(32'h200, rand256(), 1'b1);
        @(posedge clk); #1;
        enable_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        exp_dout = '0;
        check("midrst_ack", 256'(ack_o), 256'(0));
        check("midrst_data", data_o, '0);
        check("midrst_err", 256'(err_o), 256'(0));
        wait_ack(lat);
        check("midrst_no_ack", 256'(lat), 256'(0));
        @(posedge clk); #1;
        req(32'h200, '0, 1'b0, 32'h0);
        check("midrst_line16", data_o, model_mem[16]);

        // Address above the array: flagged or aliased depending on build
        req(32'h4000, rand256(), 1'b1, 32'h0);
        req(32'h0, '0, 1'b0, 32'h0);
        req(32'h4000, '0, 1'b0, 32'h0);

        // Random traffic, including aliased/out-of-range lines
        for (int n = 0; n < 40; n++) begin
            a = ($urandom_range(0, 1023) << 5) | ($urandom & 32'h1F);
            if ($urandom_range(0, 3) == 0) a[31:15] = 17'($urandom);
            req(a, rand256(), 1'($urandom), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
